// File: rtl/mem_access_unit.sv
// mem_access_unit: memory-side stage behind the multi-cycle control FSM.
// Accepts one read or write at a time from IDLE and latches all request fields.
// It then waits LATENCY cycles and signals completion with a one-cycle mem_ready.
// A completing read updates either the Instruction Register or the Memory Data Register.
// A completing write commits the latched data into the unified word memory.
module mem_access_unit #(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic        i_or_d,
    input  logic        ir_write,
    input  logic [31:0] pc,
    input  logic [31:0] alu_out,
    input  logic [31:0] write_data,
    output logic [31:0] inst,
    output logic [31:0] mdr,
    output logic        mem_ready,
    output logic        busy,
    output logic        addr_misaligned
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic                    ready_q, ready_d;
    logic                    busy_q, busy_d;

    // Request fields captured at acceptance; live inputs are ignored while BUSY.
    logic                    op_rd_q;
    logic                    op_wr_q;
    logic                    tgt_ir_q;
    logic [ADDR_WIDTH-1:0]   idx_q;
    logic [31:0]             wdata_q;

    logic [31:0]             inst_q;
    logic [31:0]             mdr_q;
    logic                    misal_q;

    logic [31:0]             mem_q [0:DEPTH-1];

    logic [31:0]             addr_s;
    logic                    accept_s;
    logic                    done_s;
    logic                    unused_addr_bits_s;

    assign addr_s   = i_or_d ? alu_out : pc;
    assign accept_s = (state_q == ST_IDLE) && (mem_read || mem_write);
    assign done_s   = (state_q == ST_BUSY) && (cnt_q == 4'd0);

    // Address bits above the word index wrap away and are deliberately unused.
    assign unused_addr_bits_s = ^addr_s[31:ADDR_WIDTH+2];

    // State register plus the registered status outputs derived from the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state logic: accept in IDLE, count down in BUSY, return on completion.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    state_d = ST_BUSY;
                    cnt_d   = 4'(LATENCY - 1);
                end else begin
                    state_d = ST_IDLE;
                    cnt_d   = cnt_q;
                end
            end
            ST_BUSY: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_IDLE;
                    cnt_d   = 4'd0;
                end else begin
                    state_d = ST_BUSY;
                    cnt_d   = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Output decode on the next state so mem_ready/busy leave flops aligned to state.
    always_comb begin
        ready_d = 1'b0;
        busy_d  = 1'b0;
        if (state_d == ST_BUSY) begin
            busy_d  = 1'b1;
            ready_d = (cnt_d == 4'd0);
        end else begin
            busy_d  = 1'b0;
            ready_d = 1'b0;
        end
    end

    // Latch the request at acceptance; a simultaneous read+write drops the read.
    always_ff @(posedge clk) begin
        if (reset) begin
            op_rd_q  <= 1'b0;
            op_wr_q  <= 1'b0;
            tgt_ir_q <= 1'b0;
            idx_q    <= '0;
            wdata_q  <= 32'd0;
        end else if (accept_s) begin
            op_rd_q  <= mem_read && !mem_write;
            op_wr_q  <= mem_write;
            tgt_ir_q <= ir_write;
            idx_q    <= addr_s[ADDR_WIDTH+1:2];
            wdata_q  <= write_data;
        end
    end

    // IR/MDR hold their value; only a completing read updates the selected one.
    always_ff @(posedge clk) begin
        if (reset) begin
            inst_q <= 32'd0;
            mdr_q  <= 32'd0;
        end else if (done_s && op_rd_q) begin
            if (tgt_ir_q) begin
                inst_q <= mem_q[idx_q];
            end else begin
                mdr_q  <= mem_q[idx_q];
            end
        end
    end

    // Sticky misalignment flag, set by any accepted access with nonzero byte offset.
    always_ff @(posedge clk) begin
        if (reset) begin
            misal_q <= 1'b0;
        end else if (accept_s && (addr_s[1:0] != 2'b00)) begin
            misal_q <= 1'b1;
        end
    end

    // Word memory: not reset; a write aborted by reset is discarded.
    always_ff @(posedge clk) begin
        if (done_s && op_wr_q && !reset) begin
            mem_q[idx_q] <= wdata_q;
        end
    end

    assign inst            = inst_q;
    assign mdr             = mdr_q;
    assign mem_ready       = ready_q;
    assign busy            = busy_q;
    assign addr_misaligned = misal_q;

endmodule
